grf_wr_arb: RTL and testbench
=============================

Name: grf_wr_arb

Overview:
- Shares the single write port of the 16x32 general register file among NREQ result producers: ALU, load/store, multiplier.
- Round-robin arbitration feeds one registered write stage, which drives the register file's write address, byte enables, data and chip select.
- Keeps a per-register pending-write scoreboard for the issue logic.
- Sits between execute-stage result sources and the register file; honours the global clock enable.

Parameters:
- NREQ, 3, number of write requesters (index 0 = ALU, 1 = LSU, 2 = MUL)
- AW, 4, register address width (2^AW registers)
- DW, 32, data width
- NBE, 4, byte-enable width (DW/8)

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_clk_en  in  1  global clock enable; state advances only on edges where it is high
- i_req  in  NREQ  per-requester write request
- i_waddr  in  NREQ*AW  destination register, requester k at [k*AW +: AW]
- i_wen  in  NREQ*NBE  byte enables, requester k at [k*NBE +: NBE]
- i_wdata  in  NREQ*DW  write data, requester k at [k*DW +: DW]
- o_gnt  out  NREQ  one-hot grant; combinational
- o_rf_waddr  out  AW  register-file write address; registered
- o_rf_wen  out  NBE  register-file byte enables; registered
- o_rf_din  out  DW  register-file write data; registered
- o_rf_cs_b  out  1  register-file chip select, active-low; registered
- i_rsv_valid  in  1  issue logic reserves a destination register
- i_rsv_addr  in  AW  register being reserved
- o_busy  out  2^AW  scoreboard, bit r = write to r pending; registered
- o_err  out  1  sticky protocol error flag

Behaviour:
- Reset (asynchronous, any time, including mid-operation) clears all state:
  - stage valid = 0, so o_rf_cs_b = 1
  - o_rf_waddr = 0, o_rf_wen = 0, o_rf_din = 0
  - o_busy = 0, o_err = 0
  - round-robin pointer = 0
  - an in-flight write is dropped, not committed.
- Arbitration (combinational):
  - Winner is the first asserted i_req scanning upward from the pointer, wrapping at NREQ-1 -> 0.
  - o_gnt = onehot(winner) when any i_req is set and i_clk_en = 1; otherwise 0.
- Request handshake:
  - A requester holds i_req, i_waddr, i_wen and i_wdata stable until it sees o_gnt[k] = 1.
  - Its request is consumed at that rising edge; it may drop i_req or present the next write in the following cycle.
  - Dropping i_req before a grant is legal (request withdrawn).
- Edge with i_clk_en = 1:
  - Stage loads the winner's addr/wen/data; stage valid = |i_req.
  - If a grant occurred, pointer <= (winner + 1) mod NREQ; otherwise the pointer holds.
- Edge with i_clk_en = 0: stage, pointer, busy and err all hold; o_gnt = 0.
- Write stage:
  - o_rf_cs_b = ~stage valid; o_rf_* are driven directly from the stage registers.
  - The register file commits at the next i_clk_en edge; the stage never backpressures.
  - Latency: grant edge -> o_rf_cs_b low next cycle -> committed at the following enabled edge.
  - Sustained throughput is one write per enabled cycle.
  - A granted request with wen = 0 still occupies a stage slot and clears busy (no data change).
- Scoreboard, evaluated on each i_clk_en edge:
  - Clear: if stage valid, busy[stage addr] <= 0 (commit edge).
  - Set: if i_rsv_valid, busy[i_rsv_addr] <= 1. Set overrides clear for the same address in the same edge.
  - Reserving a register whose busy bit is already 1 (and not being cleared that edge) sets o_err = 1; busy stays 1.
  - o_err clears only on reset.
- No ordering is enforced between requesters; issue logic must use o_busy to avoid WAW hazards.

Decomposition:
- Shared package: AW, DW, NBE defaults and requester index constants (REQ_ALU = 0, REQ_LSU = 1, REQ_MUL = 2).
- One natural sub-module: rr_arb, a parameterised round-robin arbiter (NREQ requests, pointer register, one-hot grant, i_clk_en-gated advance).
- Scoreboard and write stage stay inline in grf_wr_arb.

Test Plan:
- Reset release with no requests -> o_rf_cs_b = 1, o_busy = 0, o_gnt = 0, o_err = 0 on every cycle.
- i_req = 3'b111 held for 6 enabled cycles, pointer starting at 0 -> grants 001, 010, 100, 001, 010, 100. o_rf_waddr follows the granted requester's address one cycle later.
- Single requester 1: addr 5, wen 4'b0011, data 32'hDEAD_BEEF -> o_gnt = 3'b010 in cycle n; in cycle n+1 o_rf_cs_b = 0, o_rf_waddr = 5, o_rf_wen = 4'b0011, o_rf_din = 32'hDEAD_BEEF.
- Reserve r7 (busy[7] = 1); later requester 0 writes r7 -> busy[7] clears at the commit edge. Repeat with i_rsv_valid for r7 on that same edge -> busy[7] stays 1, o_err stays 0.
- Reserve r3 twice without an intervening commit -> o_err = 1 and stays 1 until i_rst.
- i_clk_en = 0 for 3 cycles with i_req = 3'b011 and a valid stage -> o_gnt = 0, o_rf_* and o_busy frozen.
- Assert i_rst mid-stream with the stage valid -> o_rf_cs_b = 1 and o_busy = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/grf_wr_arb_pkg.sv
// Shared sizing and requester index constants for the register-file write arbiter.
package grf_wr_arb_pkg;

   localparam int GRF_NREQ = 3;
   localparam int GRF_AW   = 4;
   localparam int GRF_DW   = 32;
   localparam int GRF_NBE  = GRF_DW / 8;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LSU  = 1;
   localparam int REQ_MUL  = 2;

endpackage

// File: rtl/grf_wr_arb_rr_arb.sv
// Round-robin arbiter: one-hot grant scanning upward from a rotating pointer.
// The pointer moves past the winner only on enabled edges that carry a grant.
import grf_wr_arb_pkg::*;

module rr_arb #(
   parameter int NREQ = GRF_NREQ
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clk_en,
   input  logic [NREQ-1:0] i_req,
   output logic [NREQ-1:0] o_gnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] winner;
   logic [PW-1:0] ptr_nxt;
   logic          found;
   int            idx;

   // pick the first active request at or above the pointer, wrapping to 0
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && i_req[PW'(idx)]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
   end

   // grant is suppressed on disabled cycles so nobody consumes a request the stage won't take
   always_comb begin
      o_gnt = '0;
      if (found && i_clk_en) o_gnt[winner] = 1'b1;
   end

   // next pointer sits just past the winner
   always_comb begin
      ptr_nxt = winner + PW'(1);
      if (winner == PW'(NREQ - 1)) ptr_nxt = '0;
   end

   // pointer register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr <= '0;
      end else if (i_clk_en && found) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/grf_wr_arb.sv
// Register-file write-port arbiter: round-robin among result producers, one
// registered write stage driving the RF port, and a per-register pending-write
// scoreboard for issue logic.
import grf_wr_arb_pkg::*;

module grf_wr_arb #(
   parameter int NREQ = GRF_NREQ,
   parameter int AW   = GRF_AW,
   parameter int DW   = GRF_DW,
   parameter int NBE  = GRF_NBE
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clk_en,
   input  logic [NREQ-1:0]     i_req,
   input  logic [NREQ*AW-1:0]  i_waddr,
   input  logic [NREQ*NBE-1:0] i_wen,
   input  logic [NREQ*DW-1:0]  i_wdata,
   output logic [NREQ-1:0]     o_gnt,
   output logic [AW-1:0]       o_rf_waddr,
   output logic [NBE-1:0]      o_rf_wen,
   output logic [DW-1:0]       o_rf_din,
   output logic                o_rf_cs_b,
   input  logic                i_rsv_valid,
   input  logic [AW-1:0]       i_rsv_addr,
   output logic [(1<<AW)-1:0]  o_busy,
   output logic                o_err
);

   localparam int NREG = 1 << AW;

   logic [NREQ-1:0] gnt;
   logic [AW-1:0]   sel_addr;
   logic [NBE-1:0]  sel_wen;
   logic [DW-1:0]   sel_data;

   logic            st_valid;
   logic [AW-1:0]   st_addr;
   logic [NBE-1:0]  st_wen;
   logic [DW-1:0]   st_data;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            rsv_conflict;

   rr_arb #(.NREQ(NREQ)) u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clk_en (i_clk_en),
      .i_req    (i_req),
      .o_gnt    (gnt)
   );

   assign o_gnt = gnt;

   // steer the granted requester's fields into the stage
   always_comb begin
      sel_addr = '0;
      sel_wen  = '0;
      sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            sel_addr = i_waddr[k*AW +: AW];
            sel_wen  = i_wen[k*NBE +: NBE];
            sel_data = i_wdata[k*DW +: DW];
         end
      end
   end

   // write stage; fields hold when nothing is granted to avoid needless toggling on the RF bus
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st_valid <= 1'b0;
         st_addr  <= '0;
         st_wen   <= '0;
         st_data  <= '0;
      end else if (i_clk_en) begin
         st_valid <= |i_req;
         if (|i_req) begin
            st_addr <= sel_addr;
            st_wen  <= sel_wen;
            st_data <= sel_data;
         end
      end
   end

   assign o_rf_cs_b  = ~st_valid;
   assign o_rf_waddr = st_addr;
   assign o_rf_wen   = st_wen;
   assign o_rf_din   = st_data;

   // commit clears, reservation sets; a same-edge reservation wins over the clear
   always_comb begin
      busy_nxt = busy;
      if (st_valid)    busy_nxt[st_addr]    = 1'b0;
      if (i_rsv_valid) busy_nxt[i_rsv_addr] = 1'b1;
   end

   // re-reserving a register that stays pending is a WAW the issue logic should have blocked
   assign rsv_conflict = i_rsv_valid && busy[i_rsv_addr]
                         && !(st_valid && (st_addr == i_rsv_addr));

   // scoreboard and sticky error
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy  <= '0;
         o_err <= 1'b0;
      end else if (i_clk_en) begin
         busy <= busy_nxt;
         if (rsv_conflict) o_err <= 1'b1;
      end
   end

   assign o_busy = busy;

endmodule

// File: tb/tb_grf_wr_arb.sv
// Self-checking bench for grf_wr_arb: expected RF writes are queued as the
// stimulus issues them and a monitor pops and compares them at each commit.
`timescale 1ns/1ps
module tb_grf_wr_arb;
   import grf_wr_arb_pkg::*;

   localparam int NREQ = GRF_NREQ;
   localparam int AW   = GRF_AW;
   localparam int DW   = GRF_DW;
   localparam int NBE  = GRF_NBE;

   typedef struct {
      logic [AW-1:0]  addr;
      logic [NBE-1:0] wen;
      logic [DW-1:0]  data;
   } wr_t;

   logic                i_clk = 1'b0;
   logic                i_rst;
   logic                i_clk_en;
   logic [NREQ-1:0]     i_req;
   logic [NREQ*AW-1:0]  i_waddr;
   logic [NREQ*NBE-1:0] i_wen;
   logic [NREQ*DW-1:0]  i_wdata;
   logic [NREQ-1:0]     o_gnt;
   logic [AW-1:0]       o_rf_waddr;
   logic [NBE-1:0]      o_rf_wen;
   logic [DW-1:0]       o_rf_din;
   logic                o_rf_cs_b;
   logic                i_rsv_valid;
   logic [AW-1:0]       i_rsv_addr;
   logic [(1<<AW)-1:0]  o_busy;
   logic                o_err;

   int  n_vec = 0;
   int  n_err = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   grf_wr_arb dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clk_en    (i_clk_en),
      .i_req       (i_req),
      .i_waddr     (i_waddr),
      .i_wen       (i_wen),
      .i_wdata     (i_wdata),
      .o_gnt       (o_gnt),
      .o_rf_waddr  (o_rf_waddr),
      .o_rf_wen    (o_rf_wen),
      .o_rf_din    (o_rf_din),
      .o_rf_cs_b   (o_rf_cs_b),
      .i_rsv_valid (i_rsv_valid),
      .i_rsv_addr  (i_rsv_addr),
      .o_busy      (o_busy),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] a, input logic [NBE-1:0] w,
                          input logic [DW-1:0] d);
      i_waddr[k*AW +: AW]   = a;
      i_wen[k*NBE +: NBE]   = w;
      i_wdata[k*DW +: DW]   = d;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [NBE-1:0] w, input logic [DW-1:0] d);
      wr_t e;
      e.addr = a;
      e.wen  = w;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // a presented write commits on an enabled edge; compare it against the queue head
   always @(negedge i_clk) begin
      if (!i_rst && i_clk_en && !o_rf_cs_b) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %h data %h expected none", o_rf_waddr, o_rf_din);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rf_waddr", 32'(o_rf_waddr), 32'(mon_e.addr));
            chk("rf_wen",   32'(o_rf_wen),   32'(mon_e.wen));
            chk("rf_din",   o_rf_din,        mon_e.data);
         end
      end
   end

   logic [NREQ-1:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [AW-1:0]   rr_addr[6] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
   logic [DW-1:0]   rr_data[6] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                                   32'hA000_0001, 32'hA000_0002, 32'hA000_0003};

   initial begin
      i_rst = 1'b1; i_clk_en = 1'b1; i_req = '0;
      i_waddr = '0; i_wen = '0; i_wdata = '0;
      i_rsv_valid = 1'b0; i_rsv_addr = '0;
      tick(); tick();
      i_rst = 1'b0;

      // idle after reset
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("idle_cs_b", 32'(o_rf_cs_b), 32'd1);
         chk("idle_busy", 32'(o_busy), 32'd0);
         chk("idle_gnt",  32'(o_gnt), 32'd0);
         chk("idle_err",  32'(o_err), 32'd0);
         tick();
      end

      // all three requesting: strict rotation
      set_req(REQ_ALU, 4'd1, 4'hF, 32'hA000_0001);
      set_req(REQ_LSU, 4'd2, 4'hF, 32'hA000_0002);
      set_req(REQ_MUL, 4'd3, 4'hF, 32'hA000_0003);
      i_req = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("rr_gnt", 32'(o_gnt), 32'(rr_exp[c]));
         push(rr_addr[c], 4'hF, rr_data[c]);
         tick();
      end
      i_req = '0;
      tick();

      // lone LSU write (pointer now 0)
      set_req(REQ_LSU, 4'd5, 4'b0011, 32'hDEAD_BEEF);
      i_req = 3'b010;
      #1;
      chk("lsu_gnt", 32'(o_gnt), 32'b010);
      push(4'd5, 4'b0011, 32'hDEAD_BEEF);
      tick();
      i_req = '0;
      #1;
      chk("lsu_cs_b", 32'(o_rf_cs_b), 32'd0);
      tick();

      // reserve r7, then ALU writes r7 and the commit clears it
      i_rsv_valid = 1'b1; i_rsv_addr = 4'd7;
      tick();
      i_rsv_valid = 1'b0;
      #1;
      chk("rsv7_busy", 32'(o_busy), 32'h0080);
      set_req(REQ_ALU, 4'd7, 4'hF, 32'h7777_0001);
      i_req = 3'b001;
      #1;
      chk("w7_gnt", 32'(o_gnt), 32'b001);
      push(4'd7, 4'hF, 32'h7777_0001);
      tick();
      i_req = '0;
      #1;
      chk("w7_busy_pre", 32'(o_busy), 32'h0080);
      tick();
      chk("w7_busy_clr", 32'(o_busy), 32'h0000);

      // same again, but re-reserve r7 on the commit edge
      i_rsv_valid = 1'b1; i_rsv_addr = 4'd7;
      tick();
      i_rsv_valid = 1'b0;
      set_req(REQ_ALU, 4'd7, 4'h0, 32'h7777_0002);
      i_req = 3'b001;
      #1;
      chk("w7b_gnt", 32'(o_gnt), 32'b001);
      push(4'd7, 4'h0, 32'h7777_0002);
      tick();
      i_req = '0;
      i_rsv_valid = 1'b1; i_rsv_addr = 4'd7;
      tick();
      i_rsv_valid = 1'b0;
      #1;
      chk("w7b_busy", 32'(o_busy), 32'h0080);
      chk("w7b_err",  32'(o_err), 32'd0);

      // clock enable low with a valid stage (pointer now 1)
      set_req(REQ_ALU, 4'd9,  4'hF, 32'hAAAA_0009);
      set_req(REQ_LSU, 4'd10, 4'hF, 32'hBBBB_000A);
      i_req = 3'b011;
      #1;
      chk("fz_gnt0", 32'(o_gnt), 32'b010);
      push(4'd10, 4'hF, 32'hBBBB_000A);
      tick();
      i_clk_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("fz_gnt",   32'(o_gnt), 32'd0);
         chk("fz_cs_b",  32'(o_rf_cs_b), 32'd0);
         chk("fz_waddr", 32'(o_rf_waddr), 32'd10);
         chk("fz_din",   o_rf_din, 32'hBBBB_000A);
         chk("fz_busy",  32'(o_busy), 32'h0080);
         tick();
      end
      i_clk_en = 1'b1;
      #1;
      chk("fz_gnt1", 32'(o_gnt), 32'b001);
      push(4'd9, 4'hF, 32'hAAAA_0009);
      tick();
      #1;
      chk("fz_gnt2", 32'(o_gnt), 32'b010);
      push(4'd10, 4'hF, 32'hBBBB_000A);
      tick();
      i_req = '0;
      tick(); tick();

      // double reservation of r3
      i_rsv_valid = 1'b1; i_rsv_addr = 4'd3;
      tick();
      #1;
      chk("r3_err_first", 32'(o_err), 32'd0);
      tick();
      i_rsv_valid = 1'b0;
      #1;
      chk("r3_err", 32'(o_err), 32'd1);
      chk("r3_busy", 32'(o_busy), 32'h0088);
      tick(); tick();
      chk("r3_err_sticky", 32'(o_err), 32'd1);

      // reset with a write in flight: dropped, outputs clear without a clock edge
      set_req(REQ_LSU, 4'd12, 4'hF, 32'hCCCC_000C);
      i_req = 3'b010;
      #1;
      chk("rst_gnt", 32'(o_gnt), 32'b010);
      tick();
      i_req = '0;
      chk("rst_cs_pre", 32'(o_rf_cs_b), 32'd0);
      i_rst = 1'b1;
      #1;
      chk("rst_cs_b", 32'(o_rf_cs_b), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_err",  32'(o_err), 32'd0);
      tick();
      i_rst = 1'b0;

      // pointer back at 0
      i_req = 3'b111;
      #1;
      chk("post_rst_gnt", 32'(o_gnt), 32'b001);
      push(4'd9, 4'hF, 32'hAAAA_0009);
      tick();
      i_req = '0;
      tick(); tick();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
